// File: rtl/mips32_pkg.sv
// rtl/mips32_pkg.sv - shared MIPS32 pipeline constants, type codes and fetch state encodings
// Purpose: common definitions imported by the fetch front end and neighbouring pipeline stages.
// Contents: default instruction address width, primary opcode constants,
//           pipeline instruction class codes, fetch FSM state encodings.
package mips32_pkg;

    localparam int ADDR_W_DEF = 10;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_SW      = 6'h2B;

    typedef enum logic [2:0] {
        PT_ALU    = 3'd0,
        PT_LOAD   = 3'd1,
        PT_STORE  = 3'd2,
        PT_BRANCH = 3'd3,
        PT_JUMP   = 3'd4
    } pipe_type_e;

    typedef enum logic [1:0] {
        F_IDLE    = 2'd0,
        F_REQ     = 2'd1,
        F_WAIT    = 2'd2,
        F_DISCARD = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/mips32_fetch_queue_fetch_fifo.sv
// rtl/mips32_fetch_queue_fetch_fifo.sv - synchronous prefetch FIFO with dominant flush
// Purpose: DEPTH-entry FIFO holding fetched {instruction, next-pc} pairs.
// Ports:
//   clk1, rst_n      clock, asynchronous active-low reset
//   push, push_data  write one entry (ignored when full unless a pop frees a slot)
//   pop              remove head (ignored when empty)
//   flush            empty the FIFO; overrides push and pop in the same cycle
//   head             current head entry (contents undefined when count == 0)
//   count            occupancy, 0..DEPTH
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 42,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic             clk1,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] head,
    output logic [CW-1:0]    count
);

    localparam logic [CW-1:0] FULL  = CW'(DEPTH);
    localparam logic [PW-1:0] P_ONE = PW'(1);
    localparam logic [CW-1:0] C_ONE = CW'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != FULL) || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + P_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + P_ONE;
            case ({do_push, do_pop})
                2'b10:   count <= count + C_ONE;
                2'b01:   count <= count - C_ONE;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: the top gates head with count != 0.
    always_ff @(posedge clk1) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/mips32_fetch_queue.sv
// rtl/mips32_fetch_queue.sv - MIPS32 instruction fetch front end with prefetch queue
// Purpose: fetches word-addressed instructions from a variable-latency memory (one
//          outstanding transaction), buffers them, and hands {ir, npc} to decode.
// Ports:
//   clk1, rst_n                        clock, asynchronous active-low reset
//   imem_req/imem_addr/imem_gnt        request channel, request held until grant
//   imem_rvalid/imem_rdata             in-order read return
//   redirect_valid/redirect_pc         taken branch: flush and restart at target
//   halt                               level, blocks new requests only
//   if_valid/if_ready/if_ir/if_npc     queue head to decode
//   q_count                            queue occupancy
module mips32_fetch_queue
    import mips32_pkg::*;
#(
    parameter int               ADDR_W   = ADDR_W_DEF,
    parameter int               DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic              clk1,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [31:0]       imem_rdata,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              halt,
    output logic              if_valid,
    input  logic              if_ready,
    output logic [31:0]       if_ir,
    output logic [31:0]       if_npc,
    output logic [CW-1:0]     q_count
);

    localparam int               WIDTH   = 32 + ADDR_W;
    localparam logic [CW:0]      DEPTH_X = (CW + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] A_ONE  = ADDR_W'(1);

    fetch_state_e      state, state_d;
    logic [ADDR_W-1:0] pc, pc_d;
    logic              push;
    logic              space;
    logic [CW:0]       occ;
    logic [WIDTH-1:0]  head;

    // The outstanding fetch already owns a slot, so it is counted before issuing.
    assign occ   = {1'b0, q_count} + {{CW{1'b0}}, (state == F_WAIT)};
    assign space = occ < DEPTH_X;

    assign imem_req  = (state == F_REQ);
    assign imem_addr = pc;
    assign if_valid  = (q_count != '0);
    assign if_ir     = if_valid ? head[WIDTH-1:ADDR_W] : 32'd0;
    assign if_npc    = if_valid ? {{(32-ADDR_W){1'b0}}, head[ADDR_W-1:0]} : 32'd0;

    always_comb begin
        state_d = state;
        pc_d    = pc;
        push    = 1'b0;
        case (state)
            F_IDLE:    if (!halt && space) state_d = F_REQ;
            F_REQ:     if (imem_gnt) begin
                           state_d = F_WAIT;
                           pc_d    = pc + A_ONE;
                       end
            F_WAIT:    if (imem_rvalid) begin
                           push    = 1'b1;
                           state_d = (space && !halt) ? F_REQ : F_IDLE;
                       end
            F_DISCARD: if (imem_rvalid) state_d = F_IDLE;
            default:   state_d = F_IDLE;
        endcase

        if (redirect_valid) begin
            pc_d = redirect_pc;
            push = 1'b0;
            case (state)
                F_IDLE:    state_d = F_IDLE;
                // A granted request still has data in flight that must be swallowed.
                // An ungranted one may be retargeted, or withdrawn when halted.
                F_REQ:     state_d = imem_gnt ? F_DISCARD : (halt ? F_IDLE : F_REQ);
                F_WAIT:    state_d = imem_rvalid ? F_IDLE : F_DISCARD;
                // A return arriving with the redirect completes the pending discard.
                F_DISCARD: state_d = imem_rvalid ? F_IDLE : F_DISCARD;
                default:   state_d = F_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state <= F_IDLE;
            pc    <= RESET_PC;
        end else begin
            state <= state_d;
            pc    <= pc_d;
        end
    end

    // While waiting, pc already holds the fetched address + 1, i.e. the npc.
    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_fifo (
        .clk1      (clk1),
        .rst_n     (rst_n),
        .push      (push),
        .push_data ({imem_rdata, pc}),
        .pop       (if_valid && if_ready),
        .flush     (redirect_valid),
        .head      (head),
        .count     (q_count)
    );

endmodule

// File: tb/tb_mips32_fetch_queue.sv
// tb/tb_mips32_fetch_queue.sv - directed self-checking bench for mips32_fetch_queue
module tb_mips32_fetch_queue;

    logic        clk1;
    logic        rst_n;
    logic        imem_req;
    logic [9:0]  imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [9:0]  redirect_pc;
    logic        halt;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_ir;
    logic [31:0] if_npc;
    logic [2:0]  q_count;

    logic        auto_mem;
    logic        man_gnt;
    logic        man_rvalid;
    logic [31:0] man_rdata;
    int          lat;
    int          pend_cnt;
    logic [9:0]  pend_addr;
    logic [31:0] mem [0:1023];

    int passed;
    int total;

    mips32_fetch_queue dut (
        .clk1           (clk1),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_ir          (if_ir),
        .if_npc         (if_npc),
        .q_count        (q_count)
    );

    initial clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    assign imem_gnt    = auto_mem ? imem_req : man_gnt;
    assign imem_rvalid = auto_mem ? (pend_cnt == 1) : man_rvalid;
    assign imem_rdata  = auto_mem ? ((pend_cnt == 1) ? mem[pend_addr] : 32'd0) : man_rdata;

    always @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            pend_cnt  <= 0;
            pend_addr <= '0;
        end else if (imem_req && imem_gnt) begin
            pend_addr <= imem_addr;
            pend_cnt  <= lat;
        end else if (pend_cnt > 0) begin
            pend_cnt <= pend_cnt - 1;
        end
    end

    task automatic step();
        @(posedge clk1);
        #1;
    endtask

    task automatic do_reset(input int latency);
        rst_n = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        halt = 1'b0;
        if_ready = 1'b0;
        auto_mem = 1'b1;
        man_gnt = 1'b0;
        man_rvalid = 1'b0;
        man_rdata = '0;
        lat = latency;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset(1);
        total++; if (imem_req !== 1'b0) $display("FAIL reset_req got %0b exp 0", imem_req); else passed++;
        total++; if (if_valid !== 1'b0) $display("FAIL reset_valid got %0b exp 0", if_valid); else passed++;
        total++; if (q_count !== 3'd0) $display("FAIL reset_count got %0d exp 0", q_count); else passed++;
        total++; if (if_ir !== 32'd0) $display("FAIL reset_ir got %h exp 0", if_ir); else passed++;
        total++; if (if_npc !== 32'd0) $display("FAIL reset_npc got %h exp 0", if_npc); else passed++;
        total++; if (imem_addr !== 10'd0) $display("FAIL reset_addr got %h exp 0", imem_addr); else passed++;
    endtask

    task automatic test_stream();
        int got;
        do_reset(1);
        if_ready = 1'b1;
        step();
        total++; if (imem_req !== 1'b1 || imem_addr !== 10'd0) $display("FAIL stream_first_req got req=%0b addr=%h exp req=1 addr=000", imem_req, imem_addr); else passed++;
        step();
        total++; if (if_valid !== 1'b0) $display("FAIL stream_valid_early got %0b exp 0", if_valid); else passed++;
        step();
        total++; if (if_valid !== 1'b1) $display("FAIL stream_valid_latency got %0b exp 1", if_valid); else passed++;
        got = 0;
        for (int c = 0; c < 60 && got < 6; c++) begin
            if (if_valid) begin
                total++; if (if_ir !== 32'hC0DE_0000 + got) $display("FAIL stream_ir%0d got %h exp %h", got, if_ir, 32'hC0DE_0000 + got); else passed++;
                total++; if (if_npc !== got + 1) $display("FAIL stream_npc%0d got %h exp %h", got, if_npc, got + 1); else passed++;
                got++;
            end
            step();
        end
        total++; if (got !== 6) $display("FAIL stream_count got %0d exp 6", got); else passed++;
    endtask

    task automatic test_fill();
        int reqs;
        do_reset(1);
        for (int c = 0; c < 20; c++) step();
        total++; if (q_count !== 3'd4) $display("FAIL fill_count got %0d exp 4", q_count); else passed++;
        total++; if (imem_req !== 1'b0) $display("FAIL fill_req got %0b exp 0", imem_req); else passed++;
        total++; if (imem_addr !== 10'd4) $display("FAIL fill_pc got %h exp 004", imem_addr); else passed++;
        total++; if (if_ir !== 32'hC0DE_0000 || if_npc !== 32'd1) $display("FAIL fill_head got %h/%h exp c0de0000/1", if_ir, if_npc); else passed++;
        if_ready = 1'b1;
        step();
        if_ready = 1'b0;
        total++; if (q_count !== 3'd3) $display("FAIL fill_pop_count got %0d exp 3", q_count); else passed++;
        total++; if (if_ir !== 32'hC0DE_0001 || if_npc !== 32'd2) $display("FAIL fill_pop_head got %h/%h exp c0de0001/2", if_ir, if_npc); else passed++;
        step();
        total++; if (imem_req !== 1'b1 || imem_addr !== 10'd4) $display("FAIL fill_refetch got req=%0b addr=%h exp req=1 addr=004", imem_req, imem_addr); else passed++;
        reqs = 0;
        for (int c = 0; c < 20; c++) begin
            if (imem_req) reqs++;
            step();
        end
        total++; if (reqs !== 1) $display("FAIL fill_single_req got %0d exp 1", reqs); else passed++;
        total++; if (q_count !== 3'd4 || imem_addr !== 10'd5) $display("FAIL fill_refill got count=%0d pc=%h exp 4/005", q_count, imem_addr); else passed++;
    endtask

    task automatic test_redirect_wait();
        int c;
        do_reset(3);
        if_ready = 1'b1;
        step();
        step();
        redirect_valid = 1'b1;
        redirect_pc = 10'h020;
        step();
        redirect_valid = 1'b0;
        total++; if (imem_req !== 1'b0 || imem_addr !== 10'h020) $display("FAIL rw_discard got req=%0b pc=%h exp req=0 pc=020", imem_req, imem_addr); else passed++;
        step();
        step();
        total++; if (q_count !== 3'd0 || if_valid !== 1'b0) $display("FAIL rw_stale_dropped got count=%0d valid=%0b exp 0/0", q_count, if_valid); else passed++;
        step();
        total++; if (imem_req !== 1'b1 || imem_addr !== 10'h020) $display("FAIL rw_target_req got req=%0b addr=%h exp req=1 addr=020", imem_req, imem_addr); else passed++;
        c = 0;
        while (!if_valid && c < 30) begin step(); c++; end
        total++; if (if_ir !== 32'h1234_0020 || if_npc !== 32'h21) $display("FAIL rw_first_ir got %h/%h exp 12340020/21", if_ir, if_npc); else passed++;
    endtask

    task automatic test_redirect_gnt_pop();
        int c;
        do_reset(1);
        for (int k = 0; k < 5; k++) step();
        total++; if (q_count !== 3'd2 || imem_req !== 1'b1 || imem_addr !== 10'd2) $display("FAIL rg_setup got count=%0d req=%0b addr=%h exp 2/1/002", q_count, imem_req, imem_addr); else passed++;
        redirect_valid = 1'b1;
        redirect_pc = 10'h040;
        if_ready = 1'b1;
        step();
        redirect_valid = 1'b0;
        if_ready = 1'b0;
        total++; if (q_count !== 3'd0 || if_valid !== 1'b0) $display("FAIL rg_flush got count=%0d valid=%0b exp 0/0", q_count, if_valid); else passed++;
        total++; if (imem_req !== 1'b0 || imem_addr !== 10'h040) $display("FAIL rg_discard got req=%0b pc=%h exp req=0 pc=040", imem_req, imem_addr); else passed++;
        step();
        total++; if (q_count !== 3'd0 || imem_req !== 1'b0) $display("FAIL rg_stale_dropped got count=%0d req=%0b exp 0/0", q_count, imem_req); else passed++;
        step();
        total++; if (imem_req !== 1'b1 || imem_addr !== 10'h040) $display("FAIL rg_target_req got req=%0b addr=%h exp req=1 addr=040", imem_req, imem_addr); else passed++;
        c = 0;
        while (!if_valid && c < 30) begin step(); c++; end
        total++; if (if_ir !== 32'h1234_0040 || if_npc !== 32'h41) $display("FAIL rg_first_ir got %h/%h exp 12340040/41", if_ir, if_npc); else passed++;
    endtask

    task automatic test_halt();
        int reqs;
        do_reset(3);
        step();
        step();
        halt = 1'b1;
        reqs = 0;
        for (int c = 0; c < 13; c++) begin
            if (imem_req) reqs++;
            step();
        end
        total++; if (reqs !== 0) $display("FAIL halt_no_req got %0d exp 0", reqs); else passed++;
        total++; if (q_count !== 3'd1) $display("FAIL halt_pushed got %0d exp 1", q_count); else passed++;
        total++; if (if_ir !== 32'hC0DE_0000 || if_npc !== 32'd1) $display("FAIL halt_head got %h/%h exp c0de0000/1", if_ir, if_npc); else passed++;
        halt = 1'b0;
        step();
        total++; if (imem_req !== 1'b1 || imem_addr !== 10'd1) $display("FAIL halt_resume got req=%0b addr=%h exp req=1 addr=001", imem_req, imem_addr); else passed++;
    endtask

    task automatic test_wrap_and_reset();
        do_reset(1);
        redirect_valid = 1'b1;
        redirect_pc = 10'h3FF;
        step();
        redirect_valid = 1'b0;
        step();
        total++; if (imem_req !== 1'b1 || imem_addr !== 10'h3FF) $display("FAIL wrap_req got req=%0b addr=%h exp req=1 addr=3ff", imem_req, imem_addr); else passed++;
        step();
        total++; if (imem_addr !== 10'h000) $display("FAIL wrap_pc got %h exp 000", imem_addr); else passed++;
        step();
        total++; if (if_ir !== 32'h5555_03FF || if_npc !== 32'd0) $display("FAIL wrap_head got %h/%h exp 555503ff/0", if_ir, if_npc); else passed++;
        total++; if (imem_req !== 1'b1 || imem_addr !== 10'h000) $display("FAIL wrap_next_req got req=%0b addr=%h exp req=1 addr=000", imem_req, imem_addr); else passed++;
        step();
        total++; if (imem_req !== 1'b0 || imem_addr !== 10'h001) $display("FAIL mid_wait got req=%0b pc=%h exp req=0 pc=001", imem_req, imem_addr); else passed++;
        auto_mem = 1'b0;
        rst_n = 1'b0;
        #1;
        total++; if (imem_req !== 1'b0 || if_valid !== 1'b0 || q_count !== 3'd0 || if_ir !== 32'd0 || imem_addr !== 10'd0)
            $display("FAIL async_reset got req=%0b valid=%0b count=%0d ir=%h pc=%h exp all 0", imem_req, if_valid, q_count, if_ir, imem_addr);
        else passed++;
        step();
        rst_n = 1'b1;
        man_rvalid = 1'b1;
        man_rdata = 32'hDEAD_BEEF;
        step();
        man_rvalid = 1'b0;
        total++; if (q_count !== 3'd0 || if_valid !== 1'b0) $display("FAIL late_rvalid got count=%0d valid=%0b exp 0/0", q_count, if_valid); else passed++;
        total++; if (imem_req !== 1'b1 || imem_addr !== 10'd0) $display("FAIL post_reset_req got req=%0b addr=%h exp req=1 addr=000", imem_req, imem_addr); else passed++;
        step();
        total++; if (imem_req !== 1'b1 || imem_addr !== 10'd0) $display("FAIL req_held got req=%0b addr=%h exp req=1 addr=000", imem_req, imem_addr); else passed++;
    endtask

    initial begin
        passed = 0;
        total = 0;
        rst_n = 1'b0;
        auto_mem = 1'b1;
        man_gnt = 1'b0;
        man_rvalid = 1'b0;
        man_rdata = '0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        halt = 1'b0;
        if_ready = 1'b0;
        lat = 1;
        for (int i = 0; i < 1024; i++) mem[i] = 32'hC0DE_0000 + i;
        mem[10'h020] = 32'h1234_0020;
        mem[10'h040] = 32'h1234_0040;
        mem[10'h3FF] = 32'h5555_03FF;

        test_reset();
        test_stream();
        test_fill();
        test_redirect_wait();
        test_redirect_gnt_pop();
        test_halt();
        test_wrap_and_reset();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
